poly_eval_horner: RTL and testbench
===================================

Name: poly_eval_horner

Overview:
- Parametrised polynomial evaluator: y = a_N·x^N + … + a_1·x + a_0, with N = DEGREE.
- Operator loads coefficients and x one at a time on shared data_in, each confirmed by a go press/release.
- Block then evaluates by Horner's method, one multiply-accumulate per cycle, and holds the result with result_valid.
- Sits between board switch/key wrappers and the hex display path. Generalises the fixed quadratic evaluator to any degree and width.

Parameters:
WIDTH, 8, data, coefficient, x and result width (≥2)
DEGREE, 2, polynomial degree N (≥1); DEGREE+1 coefficients
IDX_W, $clog2(DEGREE+2), width of load_idx (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
go  in  1  active-high load strobe (level, debounced upstream)
data_in  in  WIDTH  coefficient / x value
load_idx  out  IDX_W  item awaited: 0 = a_N … DEGREE = a_0, DEGREE+1 = x
busy  out  1  high during COMPUTE
data_result  out  WIDTH  evaluated result, mod 2^WIDTH
result_valid  out  1  data_result holds result of the last completed run

Behaviour:
- Reset (resetn=0 at posedge): state=LOAD; load_idx=0; busy=0; data_result=0; result_valid=0; coefficient, x and acc registers=0.
- States: LOAD, LOAD_WAIT, COMPUTE, DONE.
- LOAD: when go=1, capture data_in into item load_idx (a_N first, x last); go to LOAD_WAIT. When go=0, stay.
- Level-sensitive capture: go held high out of reset captures immediately.
- LOAD_WAIT: stay while go=1. When go=0:
  - load_idx<DEGREE+1: load_idx++, go to LOAD.
  - load_idx=DEGREE+1: acc<=a_N, step=DEGREE-1, go to COMPUTE.
- COMPUTE: each cycle acc<=acc·x + a_step, truncated to WIDTH; step decrements.
  - Lasts exactly DEGREE cycles; busy=1 throughout.
  - Final step (step=0): data_result<=new acc; go to DONE.
  - go ignored in COMPUTE.
- DONE: result_valid=1; data_result stable; load_idx=0.
  - go=1: capture data_in as a_N, result_valid<=0, load_idx stays 0, go to LOAD_WAIT.
  - data_result keeps the old value until the next run completes.
- Latency: DEGREE+1 cycles from the first cycle go is seen low in the x LOAD_WAIT to result_valid=1.
- Arithmetic: unsigned; product and sum computed at 2·WIDTH+1 bits, low WIDTH bits kept.
- Reset mid-load or mid-compute: aborts immediately to reset values; no partial result is published.
- Coefficients persist only within a run; every run reloads all DEGREE+2 items.

Optional Feature:
- Macro POLY_EVAL_OVF_EN.
- Defined: extra output port overflow (1 bit, reset 0).
  - Sticky: set if any COMPUTE step's full-precision value ≥ 2^WIDTH.
  - Cleared when a new run starts (a_N capture).
  - Meaningful when result_valid=1.
- Undefined: no port and no overflow logic; truncation is silent.

Decomposition:
- Package poly_eval_pkg:
  - state enum (LOAD, LOAD_WAIT, COMPUTE, DONE).
  - helper function for IDX_W.
  - default WIDTH/DEGREE constants.
- Sub-module poly_eval_mac: combinational acc·x+c at parameter WIDTH, returning the truncated sum and an overflow bit (bit ignored when POLY_EVAL_OVF_EN is off).
- Top keeps the FSM, the counter and the coefficient register array.

Test Plan:
- WIDTH=8, DEGREE=2; load 2,3,4, x=5 with go pulses → busy for 2 cycles; data_result=0x45 (69); result_valid=1; load_idx=0.
- WIDTH=8, DEGREE=2; a=255,0,0, x=2 → data_result=0xFC; overflow=1 with macro defined, port absent without.
- WIDTH=8, DEGREE=3; a=1,0,0,1, x=3 → data_result=28 after 3 COMPUTE cycles; load_idx steps 0..4 during load.
- Hold go high for 10 cycles per item → exactly one capture per press; load_idx advances only on release.
- Assert resetn=0 during second COMPUTE cycle → next cycle all outputs 0, state LOAD; a following full run gives the correct result.
- From DONE (result 69), press go with data_in=1 → result_valid drops that cycle, data_result stays 69 until the new run completes.

Source files
------------

// File: rtl/poly_eval_pkg.sv
// Shared types and defaults for the Horner polynomial evaluator.
// Provides the FSM state enum, default sizes and the load index width helper.
package poly_eval_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEGREE = 2;

  typedef enum logic [1:0] {
    LOAD,
    LOAD_WAIT,
    COMPUTE,
    DONE
  } state_t;

  // Indices 0..DEGREE+1 cover DEGREE+1 coefficients plus x.
  function automatic int idx_w(input int degree);
    return $clog2(degree + 2);
  endfunction

endpackage

// File: rtl/poly_eval_mac.sv
// Combinational multiply-accumulate: sum = acc*x + c, truncated to WIDTH.
// Ports: acc, x, c in; sum out; ovf out only with POLY_EVAL_OVF_EN.
module poly_eval_mac #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum
`ifdef POLY_EVAL_OVF_EN
  ,
  output logic             ovf
`endif
);

`ifdef POLY_EVAL_OVF_EN
  localparam int FW = 2 * WIDTH + 1;

  logic [FW-1:0] full;

  always_comb begin
    full = FW'(acc) * FW'(x) + FW'(c);
  end

  assign sum = full[WIDTH-1:0];
  assign ovf = |full[FW-1:WIDTH];
`else
  // Low WIDTH bits of the wide result equal
  // the WIDTH-bit modular result.
  logic [WIDTH-1:0] full;

  always_comb begin
    full = acc * x + c;
  end

  assign sum = full;
`endif

endmodule

// File: rtl/poly_eval_horner.sv
// Horner polynomial evaluator: loads a_N..a_0 then x via go, then one MAC/cycle.
// Ports: clk, resetn, go, data_in / load_idx, busy, data_result, result_valid
// (+ overflow when POLY_EVAL_OVF_EN is defined).
module poly_eval_horner
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEGREE = DEF_DEGREE,
  parameter int IDX_W  = idx_w(DEGREE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [IDX_W-1:0] load_idx,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic             result_valid
`ifdef POLY_EVAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [IDX_W-1:0] X_IDX   = IDX_W'(DEGREE + 1);
  localparam logic [IDX_W-1:0] LAST_CI = IDX_W'(DEGREE);

  state_t           state;
  // items[0] = a_N ... items[DEGREE] = a_0, items[DEGREE+1] = x
  logic [WIDTH-1:0] items [DEGREE+2];
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] ci;
  logic [WIDTH-1:0] mac_sum;

`ifdef POLY_EVAL_OVF_EN
  logic mac_ovf;
`endif

  poly_eval_mac #(
    .WIDTH(WIDTH)
  ) u_mac (
    .acc(acc),
    .x  (items[DEGREE+1]),
    .c  (items[ci]),
    .sum(mac_sum)
`ifdef POLY_EVAL_OVF_EN
    ,
    .ovf(mac_ovf)
`endif
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= LOAD;
      load_idx     <= '0;
      busy         <= 1'b0;
      data_result  <= '0;
      result_valid <= 1'b0;
      acc          <= '0;
      ci           <= '0;
      for (int i = 0; i < DEGREE + 2; i++)
        items[i] <= '0;
`ifdef POLY_EVAL_OVF_EN
      overflow     <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (go) begin
            items[load_idx] <= data_in;
            state           <= LOAD_WAIT;
`ifdef POLY_EVAL_OVF_EN
            if (load_idx == '0)
              overflow <= 1'b0;
`endif
          end
        end
        LOAD_WAIT: begin
          if (!go) begin
            if (load_idx != X_IDX) begin
              load_idx <= load_idx + 1'b1;
              state    <= LOAD;
            end else begin
              acc   <= items[0];
              ci    <= IDX_W'(1);
              busy  <= 1'b1;
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc <= mac_sum;
`ifdef POLY_EVAL_OVF_EN
          overflow <= overflow | mac_ovf;
`endif
          if (ci == LAST_CI) begin
            data_result  <= mac_sum;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            load_idx     <= '0;
            state        <= DONE;
          end else begin
            ci <= ci + 1'b1;
          end
        end
        DONE: begin
          if (go) begin
            items[0]     <= data_in;
            result_valid <= 1'b0;
            state        <= LOAD_WAIT;
`ifdef POLY_EVAL_OVF_EN
            overflow     <= 1'b0;
`endif
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench for poly_eval_horner at DEGREE=2 and DEGREE=3, WIDTH=8.
// Checks overflow only when POLY_EVAL_OVF_EN is defined.
module tb_poly_eval_horner;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go2 = 1'b0;
  logic       go3 = 1'b0;
  logic [7:0] data_in = '0;

  logic [1:0] idx2;
  logic       busy2;
  logic [7:0] res2;
  logic       rv2;
  logic [2:0] idx3;
  logic       busy3;
  logic [7:0] res3;
  logic       rv3;
`ifdef POLY_EVAL_OVF_EN
  logic       ovf2;
  logic       ovf3;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  poly_eval_horner #(
    .WIDTH (8),
    .DEGREE(2)
  ) u_d2 (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go2),
    .data_in     (data_in),
    .load_idx    (idx2),
    .busy        (busy2),
    .data_result (res2),
    .result_valid(rv2)
`ifdef POLY_EVAL_OVF_EN
    ,
    .overflow    (ovf2)
`endif
  );

  poly_eval_horner #(
    .WIDTH (8),
    .DEGREE(3)
  ) u_d3 (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go3),
    .data_in     (data_in),
    .load_idx    (idx3),
    .busy        (busy3),
    .data_result (res3),
    .result_valid(rv3)
`ifdef POLY_EVAL_OVF_EN
    ,
    .overflow    (ovf3)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_idx(input int sel);
    return (sel == 2) ? int'(idx2) : int'(idx3);
  endfunction

  // One go press; load_idx must not move while go is held.
  task automatic press(input int sel,
                       input logic [7:0] v,
                       input int hold);
    int pre;
    pre = cur_idx(sel);
    data_in = v;
    if (sel == 2) go2 = 1'b1;
    else go3 = 1'b1;
    repeat (hold) tick();
    chk("hold_idx", cur_idx(sel), pre);
    go2 = 1'b0;
    go3 = 1'b0;
    tick();
  endtask

  task automatic load2(input logic [7:0] a2, a1, a0, xv,
                       input int hold);
    press(2, a2, hold);
    chk("idx2_a1", idx2, 1);
    press(2, a1, hold);
    chk("idx2_a0", idx2, 2);
    press(2, a0, hold);
    chk("idx2_x", idx2, 3);
    press(2, xv, hold);
    chk("busy2_c0", busy2, 1);
  endtask

  task automatic finish2(input logic [7:0] exp);
    tick();
    chk("busy2_c1", busy2, 1);
    chk("rv2_c1", rv2, 0);
    tick();
    chk("busy2_end", busy2, 0);
    chk("rv2_end", rv2, 1);
    chk("res2", res2, exp);
    chk("idx2_done", idx2, 0);
  endtask

  initial begin
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_idx", idx2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_res", res2, 0);
    chk("rst_rv", rv2, 0);
    chk("rst_idx3", idx3, 0);
    chk("rst_rv3", rv3, 0);
    resetn = 1'b1;
    tick();

    // 2x^2+3x+4 at x=5 = 69
    load2(8'd2, 8'd3, 8'd4, 8'd5, 1);
    chk("rv2_load", rv2, 0);
    finish2(8'd69);
`ifdef POLY_EVAL_OVF_EN
    chk("ovf_69", ovf2, 0);
`endif

    // New run from DONE with long presses; old result held.
    data_in = 8'd1;
    go2 = 1'b1;
    tick();
    chk("done_rv_drop", rv2, 0);
    chk("done_res_hold", res2, 69);
    chk("done_idx", idx2, 0);
    repeat (9) tick();
    chk("done_hold_idx", idx2, 0);
    go2 = 1'b0;
    tick();
    chk("done_rel_idx", idx2, 1);
    press(2, 8'd1, 10);
    chk("h_idx2", idx2, 2);
    press(2, 8'd1, 10);
    chk("h_idx3", idx2, 3);
    press(2, 8'd2, 10);
    chk("h_res_old", res2, 69);
    chk("h_rv_low", rv2, 0);
    finish2(8'd7);

    // 255x^2 at x=2 wraps to 0xFC
    load2(8'd255, 8'd0, 8'd0, 8'd2, 1);
    finish2(8'hFC);
`ifdef POLY_EVAL_OVF_EN
    chk("ovf_fc", ovf2, 1);
`endif

    // Reset during second COMPUTE cycle
    load2(8'd2, 8'd3, 8'd4, 8'd5, 1);
    tick();
    chk("mid_busy", busy2, 1);
    resetn = 1'b0;
    tick();
    chk("ab_idx", idx2, 0);
    chk("ab_busy", busy2, 0);
    chk("ab_res", res2, 0);
    chk("ab_rv", rv2, 0);
`ifdef POLY_EVAL_OVF_EN
    chk("ab_ovf", ovf2, 0);
`endif
    resetn = 1'b1;
    tick();
    load2(8'd2, 8'd3, 8'd4, 8'd5, 1);
    finish2(8'd69);

    // DEGREE=3: x^3+1 at x=3 = 28
    chk("d3_idx0", idx3, 0);
    press(3, 8'd1, 1);
    chk("d3_idx1", idx3, 1);
    press(3, 8'd0, 1);
    chk("d3_idx2", idx3, 2);
    press(3, 8'd0, 1);
    chk("d3_idx3", idx3, 3);
    press(3, 8'd1, 1);
    chk("d3_idx4", idx3, 4);
    press(3, 8'd3, 1);
    chk("d3_busy0", busy3, 1);
    tick();
    chk("d3_busy1", busy3, 1);
    tick();
    chk("d3_busy2", busy3, 1);
    chk("d3_rv2", rv3, 0);
    tick();
    chk("d3_busy3", busy3, 0);
    chk("d3_rv", rv3, 1);
    chk("d3_res", res3, 28);
    chk("d3_idx_done", idx3, 0);
`ifdef POLY_EVAL_OVF_EN
    chk("d3_ovf", ovf3, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
